jtag_debug_cmd_sync: RTL and testbench

Parametrised clk-domain receiver for the CPU virtual-JTAG debug path. It synchronises the TCK-domain update strobes (vs_uir, vs_udr) into clk and latches the instruction register and shift register on each update. Each command is queued in a small FIFO and issued one at a time as a one-cycle take_action/take_no_action strobe per instruction channel, with jdo held valid. It generalises the fixed 38-bit/2-bit-IR debug sysclk stage: configurable widths and sync depth, command queuing, a consumer throttle and sticky overflow status.

---
 rtl/jtag_debug_cmd_sync.sv | 178 +++++++++++++++++
 tb/tb_jtag_debug_cmd_sync.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_sync.sv
// Small command FIFO: push/pop with registered pointers and occupancy.
// Latency: a pushed entry is readable at the head on the next cycle.
// Backpressure: none internally; the caller must not push when full without popping.
module jtag_cmd_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_rdy)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_vld, pop_rdy})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// Virtual-JTAG debug receiver: synchronises update strobes, queues {ir, sr} commands, issues strobes.
// Latency: vs_udr rise to channel strobe is SYNC_STAGES+3 clk with an empty queue; >=3 clk per command.
// Backpressure: issue_en=0 holds commands in the queue; a push into a full queue is dropped and flagged.
module jtag_debug_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACTION_BIT  = 37,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    vs_uir,
    input  logic                    vs_udr,
    input  logic [IR_W-1:0]         ir_in,
    input  logic [DATA_W-1:0]       sr,
    input  logic                    issue_en,
    input  logic                    clr_ovf,
    output logic [DATA_W-1:0]       jdo,
    output logic [IR_W-1:0]         jdo_ir,
    output logic [(1<<IR_W)-1:0]    take_action,
    output logic [(1<<IR_W)-1:0]    take_no_action,
    output logic [$clog2(DEPTH):0]  cmd_level,
    output logic                    overflow
);
    localparam int NUM_CH = 1 << IR_W;
    localparam int AW     = $clog2(DEPTH);

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] dat;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_hist, uir_hist;
    logic [2:0]             warm;
    logic                   armed;
    logic                   udr_evt, uir_evt;
    logic [IR_W-1:0]        ir_q;
    logic                   full, pop, drop, push;
    cmd_t                   push_cmd, head_cmd;
    state_t                 state;
    logic [NUM_CH-1:0]      ch_onehot;

    // Edge detection stays disarmed until the history flop holds a genuinely
    // sampled level, so a strobe already high at reset release is not an edge.
    assign armed   = (warm == 3'(SYNC_STAGES + 1));
    assign udr_evt = armed && udr_sync[SYNC_STAGES-1] && !udr_hist;
    assign uir_evt = armed && uir_sync[SYNC_STAGES-1] && !uir_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
            warm     <= '0;
            ir_q     <= '0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
            if (!armed) warm <= warm + 3'd1;
            if (uir_evt) ir_q <= ir_in;
        end
    end

    // The push below sees the pre-update ir_q: update-DR precedes update-IR on the TCK side.
    assign push_cmd = '{ir: ir_q, dat: sr};
    assign full     = (cmd_level == (AW+1)'(DEPTH));
    assign pop      = (state == IDLE) && (cmd_level != '0) && issue_en;
    assign drop     = udr_evt && full && !pop;
    assign push     = udr_evt && !drop;

    jtag_cmd_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (push),
        .push_dat (push_cmd),
        .pop_rdy  (pop),
        .head_dat (head_cmd),
        .level    (cmd_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign ch_onehot = NUM_CH'(1) << jdo_ir;

    // jdo loads on the pop edge; the strobe register fires one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            jdo            <= '0;
            jdo_ir         <= '0;
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        jdo    <= head_cmd.dat;
                        jdo_ir <= head_cmd.ir;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (jdo[ACTION_BIT]) take_action    <= ch_onehot;
                    else                 take_no_action <= ch_onehot;
                    state <= GAP;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Bench for jtag_debug_cmd_sync: directed scenarios plus randomized command stream,
// checked against a queue of expected commands derived from the update-strobe order.
module tb_jtag_debug_cmd_sync;
    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int NUM_CH      = 4;
    localparam int ACTION_BIT  = 37;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b1;
    logic                vs_uir = 1'b0;
    logic                vs_udr = 1'b0;
    logic [IR_W-1:0]     ir_in = '0;
    logic [DATA_W-1:0]   sr = '0;
    logic                issue_en = 1'b0;
    logic                clr_ovf = 1'b0;
    logic [DATA_W-1:0]   jdo;
    logic [IR_W-1:0]     jdo_ir;
    logic [NUM_CH-1:0]   take_action;
    logic [NUM_CH-1:0]   take_no_action;
    logic [$clog2(DEPTH):0] cmd_level;
    logic                overflow;

    jtag_debug_cmd_sync #(
        .DATA_W (DATA_W), .IR_W (IR_W), .ACTION_BIT (ACTION_BIT),
        .SYNC_STAGES (SYNC_STAGES), .DEPTH (DEPTH)
    ) dut (
        .clk (clk), .reset_n (reset_n), .vs_uir (vs_uir), .vs_udr (vs_udr),
        .ir_in (ir_in), .sr (sr), .issue_en (issue_en), .clr_ovf (clr_ovf),
        .jdo (jdo), .jdo_ir (jdo_ir), .take_action (take_action),
        .take_no_action (take_no_action), .cmd_level (cmd_level), .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] dat;
    } cmd_t;

    typedef struct {
        int unsigned       cyc;
        logic [NUM_CH-1:0] ta;
        logic [NUM_CH-1:0] tna;
    } strb_t;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    cmd_t        exp_q[$];
    strb_t       seen[$];
    logic [IR_W-1:0]   model_ir = '0;
    logic              strb_prev = 1'b0;
    logic [DATA_W-1:0] jdo_prev = '0;
    cmd_t              mon_exp;
    strb_t             mon_rec;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe is matched against the next expected command in arrival order.
    always @(negedge clk) begin
        if (reset_n && ((|take_action) || (|take_no_action))) begin
            mon_rec.cyc = cyc;
            mon_rec.ta  = take_action;
            mon_rec.tna = take_no_action;
            seen.push_back(mon_rec);
            check_eq("strb_onehot", 64'($countones({take_action, take_no_action})), 64'd1);
            check_eq("strb_gap", 64'(strb_prev), 64'd0);
            check_eq("jdo_early", 64'(jdo_prev), 64'(jdo));
            check_eq("strb_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("strb_data", 64'(jdo), 64'(mon_exp.dat));
                check_eq("strb_ch", 64'(take_action | take_no_action), 64'(NUM_CH'(1) << mon_exp.ir));
                check_eq("strb_kind", 64'(|take_action), 64'(mon_exp.dat[ACTION_BIT]));
                check_eq("strb_jdo_ir", 64'(jdo_ir), 64'(mon_exp.ir));
            end
        end
        strb_prev <= (|take_action) || (|take_no_action);
        jdo_prev  <= jdo;
    end

    task automatic send(input bit u, input bit d, input logic [IR_W-1:0] ir,
                        input logic [DATA_W-1:0] dat, input bit push, input int hi, input int lo);
        cmd_t c;
        if (d && push) begin
            c.ir  = model_ir;
            c.dat = dat;
            exp_q.push_back(c);
        end
        if (u) model_ir = ir;
        @(negedge clk);
        if (u) ir_in = ir;
        if (d) sr = dat;
        vs_uir = u;
        vs_udr = d;
        repeat (hi) @(negedge clk);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(exp_q.size()), 64'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic lat_test(input string tag, input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] dat,
                            input logic [NUM_CH-1:0] ta_exp, input logic [NUM_CH-1:0] tna_exp);
        int unsigned c0;
        int n0;
        int k;
        cmd_t c;
        send(1'b1, 1'b0, ir, '0, 1'b0, 3, 3);
        @(negedge clk);
        c0 = cyc;
        n0 = seen.size();
        c.ir  = model_ir;
        c.dat = dat;
        exp_q.push_back(c);
        sr = dat;
        vs_udr = 1'b1;
        repeat (4) @(negedge clk);
        vs_udr = 1'b0;
        check_eq({tag, "_jdo_before"}, 64'(jdo[31:0]), 64'(dat[31:0]));
        k = 0;
        while (seen.size() == n0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_seen"}, 64'(seen.size()), 64'(n0 + 1));
        if (seen.size() > n0) begin
            check_eq({tag, "_latency"}, 64'(seen[n0].cyc - c0), 64'(SYNC_STAGES + 3));
            check_eq({tag, "_ta"}, 64'(seen[n0].ta), 64'(ta_exp));
            check_eq({tag, "_tna"}, 64'(seen[n0].tna), 64'(tna_exp));
        end
        @(negedge clk);
        check_eq({tag, "_jdo_held"}, 64'(jdo), 64'(dat));
        check_eq({tag, "_strb_low"}, 64'({take_action, take_no_action}), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [DATA_W-1:0] d;
        int kind;
        bit prev_stall;

        // Reset with vs_udr already high: no command may come out of it.
        vs_udr = 1'b1;
        sr = DATA_W'(38'h2A);
        issue_en = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_jdo", 64'(jdo), 64'd0);
        check_eq("rst_jdo_ir", 64'(jdo_ir), 64'd0);
        check_eq("rst_strb", 64'({take_action, take_no_action}), 64'd0);
        check_eq("rst_level", 64'(cmd_level), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rel_level", 64'(cmd_level), 64'd0);
        check_eq("rel_no_strb", 64'(seen.size()), 64'd0);
        vs_udr = 1'b0;
        repeat (5) @(negedge clk);

        lat_test("act", 2'b01, {1'b1, 5'd0, 32'hDEADBEEF}, 4'b0010, 4'b0000);
        lat_test("noact", 2'b11, {1'b0, 5'd3, 32'h12345678}, 4'b0000, 4'b1000);

        // Stalled consumer: five events into a four-entry queue.
        issue_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = DATA_W'({$urandom(), $urandom()});
            send(1'b0, 1'b1, '0, d, i < DEPTH, 3, 3);
        end
        check_eq("stall_level", 64'(cmd_level), 64'(DEPTH));
        check_eq("stall_ovf", 64'(overflow), 64'd1);
        @(negedge clk);
        sr = DATA_W'({$urandom(), $urandom()});
        vs_udr = 1'b1;
        clr_ovf = 1'b1;
        repeat (3) @(negedge clk);
        clr_ovf = 1'b0;
        check_eq("drop_beats_clr", 64'(overflow), 64'd1);
        repeat (2) @(negedge clk);
        vs_udr = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("drop_level", 64'(cmd_level), 64'(DEPTH));
        n0 = seen.size();
        issue_en = 1'b1;
        drain("stall_drain");
        repeat (10) @(negedge clk);
        check_eq("stall_count", 64'(seen.size() - n0), 64'(DEPTH));
        for (int i = 1; i < DEPTH; i++) begin
            if (seen.size() >= n0 + DEPTH)
                check_eq("stall_spacing", 64'(seen[n0+i].cyc - seen[n0+i-1].cyc), 64'd3);
        end
        check_eq("ovf_sticky", 64'(overflow), 64'd1);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check_eq("ovf_cleared", 64'(overflow), 64'd0);

        // Full queue, new event lands on the pop edge.
        issue_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d = DATA_W'({$urandom(), $urandom()});
            send(1'b0, 1'b1, '0, d, 1'b1, 3, 3);
        end
        check_eq("full_level", 64'(cmd_level), 64'(DEPTH));
        n0 = seen.size();
        d = DATA_W'({$urandom(), $urandom()});
        begin
            cmd_t c;
            c.ir  = model_ir;
            c.dat = d;
            exp_q.push_back(c);
        end
        @(negedge clk);
        sr = d;
        vs_udr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        issue_en = 1'b1;
        @(negedge clk);
        check_eq("pushpop_level", 64'(cmd_level), 64'(DEPTH));
        check_eq("pushpop_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        vs_udr = 1'b0;
        drain("pushpop_drain");
        check_eq("pushpop_count", 64'(seen.size() - n0), 64'(DEPTH + 1));

        // Coincident update-IR and update-DR: the push keeps the old IR.
        send(1'b1, 1'b0, 2'd0, '0, 1'b0, 3, 3);
        n0 = seen.size();
        send(1'b1, 1'b1, 2'd2, DATA_W'({$urandom(), $urandom()}), 1'b1, 4, 4);
        send(1'b0, 1'b1, '0, DATA_W'({$urandom(), $urandom()}), 1'b1, 4, 4);
        drain("same_drain");
        if (seen.size() >= n0 + 2) begin
            check_eq("same_old_ch", 64'(seen[n0].ta | seen[n0].tna), 64'b0001);
            check_eq("same_new_ch", 64'(seen[n0+1].ta | seen[n0+1].tna), 64'b0100);
        end else begin
            check_eq("same_count", 64'(seen.size() - n0), 64'd2);
        end

        // Random stream with short consumer stalls that never overfill the queue.
        prev_stall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            d = DATA_W'({$urandom(), $urandom()});
            issue_en = prev_stall ? 1'b1 : ($urandom_range(0, 3) != 0);
            prev_stall = !issue_en;
            send(kind != 1, kind != 0, IR_W'($urandom_range(0, NUM_CH - 1)), d, 1'b1,
                 int'($urandom_range(3, 6)), int'($urandom_range(3, 6)));
        end
        issue_en = 1'b1;
        drain("rand_drain");
        check_eq("rand_level", 64'(cmd_level), 64'd0);
        check_eq("rand_no_ovf", 64'(overflow), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
